pwm_motor_ctrl: RTL and testbench

Multi-channel PWM motor controller: the parametrised successor to the single-channel, switch-selected DC motor PWM generator. It produces `CH` independent PWM outputs that share one programmable prescaler and one period counter. Each channel has a full-resolution duty target, soft-start/stop ramping, and a safe direction-reversal sequence. It sits between the bike-control register logic, which supplies period, duties and directions, and the motor driver pins.

---
 rtl/pwm_motor_ctrl.sv | 154 +++++++++++++++
 tb/tb_pwm_motor_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_motor_ctrl.sv
// Multi-channel PWM motor controller: shared prescaler and period counter,
// per-channel soft ramping and drain-to-zero before any direction reversal.
module pwm_motor_ctrl #(
  parameter int CH        = 2,
  parameter int CNT_W     = 12,
  parameter int PRESC_W   = 8,
  parameter int RAMP_STEP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PRESC_W-1:0]  presc,
  input  logic [CNT_W-1:0]    period,
  input  logic [CH*CNT_W-1:0] duty_tgt,
  input  logic [CH-1:0]       dir_in,
  output logic [CH-1:0]       pwm_out,
  output logic [CH-1:0]       dir_out,
  output logic [CH-1:0]       ramp_busy,
  output logic                period_start
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ch_state_e;

  // One ramp step from cur toward tgt, done one bit wider so it can never wrap.
  function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
    logic [CNT_W:0] step_v;
    logic [CNT_W:0] sum_v;
    logic [CNT_W:0] diff_v;
    step_v = (CNT_W+1)'(RAMP_STEP);
    sum_v  = {1'b0, cur} + step_v;
    diff_v = {1'b0, cur} - {1'b0, tgt};
    if (RAMP_STEP == 0) begin
      ramp_toward = tgt;
    end else if (cur < tgt) begin
      ramp_toward = (sum_v > {1'b0, tgt}) ? tgt : sum_v[CNT_W-1:0];
    end else begin
      ramp_toward = (diff_v <= step_v) ? tgt : (cur - step_v[CNT_W-1:0]);
    end
  endfunction

  logic [PRESC_W-1:0] presc_cnt_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   period_q_r;
  logic [CNT_W-1:0]   cur_r     [CH];
  logic [CNT_W-1:0]   cur_nx_s  [CH];
  logic [CNT_W-1:0]   tgt_q_r   [CH];
  logic [CNT_W-1:0]   tgt_nx_s  [CH];
  ch_state_e          state_r   [CH];
  ch_state_e          state_nx_s[CH];
  logic [CH-1:0]      dir_nx_s;
  logic [CH-1:0]      busy_nx_s;
  logic               tick_s;
  logic               boundary_s;

  assign tick_s     = en && (presc_cnt_r == presc);
  assign boundary_s = tick_s && (cnt_r == period_q_r);

  // Prescaler, period counter, latched period and period-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_r  <= '0;
      cnt_r        <= '0;
      period_q_r   <= '0;
      period_start <= 1'b0;
    end else if (!en) begin
      presc_cnt_r  <= '0;
      cnt_r        <= '0;
      period_q_r   <= period;
      period_start <= 1'b0;
    end else begin
      presc_cnt_r  <= tick_s ? '0 : (presc_cnt_r + PRESC_W'(1));
      if (boundary_s) begin
        cnt_r      <= '0;
        period_q_r <= period;
      end else if (tick_s) begin
        cnt_r      <= cnt_r + CNT_W'(1);
      end
      period_start <= boundary_s;
    end
  end

  // Per-channel next state: ramp, drain, and toggle direction only once drained.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cur_nx_s[i]   = cur_r[i];
      state_nx_s[i] = state_r[i];
      dir_nx_s[i]   = dir_out[i];
      tgt_nx_s[i]   = tgt_q_r[i];
      if (!en) begin
        cur_nx_s[i]   = '0;
        state_nx_s[i] = ST_RUN;
        dir_nx_s[i]   = dir_in[i];
      end else if (boundary_s) begin
        tgt_nx_s[i] = duty_tgt[i*CNT_W +: CNT_W];
        case (state_r[i])
          ST_RUN: begin
            if (dir_in[i] == dir_out[i]) begin
              cur_nx_s[i] = ramp_toward(cur_r[i], tgt_nx_s[i]);
            end else begin
              state_nx_s[i] = ST_DRAIN;
              cur_nx_s[i]   = ramp_toward(cur_r[i], {CNT_W{1'b0}});
            end
          end
          ST_DRAIN: begin
            if (dir_in[i] == dir_out[i]) begin
              state_nx_s[i] = ST_RUN;
              cur_nx_s[i]   = ramp_toward(cur_r[i], tgt_nx_s[i]);
            end else if (cur_r[i] == {CNT_W{1'b0}}) begin
              state_nx_s[i] = ST_RUN;
              dir_nx_s[i]   = ~dir_out[i];
            end else begin
              cur_nx_s[i]   = ramp_toward(cur_r[i], {CNT_W{1'b0}});
            end
          end
          default: begin
            state_nx_s[i] = ST_RUN;
            cur_nx_s[i]   = '0;
          end
        endcase
      end else begin
        cur_nx_s[i] = cur_r[i];
      end
      busy_nx_s[i] = (cur_nx_s[i] != tgt_nx_s[i]) || (state_nx_s[i] == ST_DRAIN);
    end
  end

  // Channel registers; the PWM compare uses the pre-edge count so it lags cnt by one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        cur_r[i]   <= '0;
        tgt_q_r[i] <= '0;
        state_r[i] <= ST_RUN;
      end
      pwm_out   <= '0;
      dir_out   <= '0;
      ramp_busy <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cur_r[i]   <= cur_nx_s[i];
        tgt_q_r[i] <= tgt_nx_s[i];
        state_r[i] <= state_nx_s[i];
        pwm_out[i] <= en && (cnt_r < cur_r[i]);
      end
      dir_out   <= dir_nx_s;
      ramp_busy <= busy_nx_s;
    end
  end

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Bench for pwm_motor_ctrl: two instances (immediate and stepped ramp) driven together
// and compared every clk against a period-level reference model.
module tb_pwm_motor_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  presc;
  logic [11:0] period;
  logic [23:0] duty_tgt;
  logic [1:0]  dir_in;
  logic [1:0]  pwm_o  [2];
  logic [1:0]  dir_o  [2];
  logic [1:0]  busy_o [2];
  logic        ps_o   [2];

  int total = 0;
  int bad   = 0;

  pwm_motor_ctrl #(.CH(2), .CNT_W(12), .PRESC_W(8), .RAMP_STEP(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .presc(presc), .period(period),
    .duty_tgt(duty_tgt), .dir_in(dir_in), .pwm_out(pwm_o[0]), .dir_out(dir_o[0]),
    .ramp_busy(busy_o[0]), .period_start(ps_o[0]));

  pwm_motor_ctrl #(.CH(2), .CNT_W(12), .PRESC_W(8), .RAMP_STEP(2)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .presc(presc), .period(period),
    .duty_tgt(duty_tgt), .dir_in(dir_in), .pwm_out(pwm_o[1]), .dir_out(dir_o[1]),
    .ramp_busy(busy_o[1]), .period_start(ps_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time measured in clks since the start of the current period.
  int         m_clk [2];
  int         m_pq  [2];
  int         m_cur [2][2];
  int         m_tgt [2][2];
  bit         m_drn [2][2];
  logic [1:0] m_dir [2];
  logic [1:0] e_pwm [2];
  logic [1:0] e_busy[2];
  logic       e_ps  [2];

  function automatic int step_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int toward(input int a, input int b, input int s);
    if (s == 0) return b;
    if (a < b) return (a + s > b) ? b : a + s;
    return (a - s < b) ? b : a - s;
  endfunction

  task automatic model_clear(input int d);
    m_clk[d] = 0; m_pq[d] = 0; m_dir[d] = 2'b00;
    e_pwm[d] = 2'b00; e_busy[d] = 2'b00; e_ps[d] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_cur[d][c] = 0; m_tgt[d][c] = 0; m_drn[d][c] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_clear(d);
      end else if (!en) begin
        m_clk[d] = 0; m_pq[d] = int'(period); m_dir[d] = dir_in;
        e_pwm[d] = 2'b00; e_ps[d] = 1'b0;
        for (int c = 0; c < 2; c++) begin
          m_cur[d][c] = 0; m_drn[d][c] = 1'b0;
          e_busy[d][c] = (m_tgt[d][c] != 0);
        end
      end else begin
        int  cnt_now;
        bit  bnd;
        cnt_now = m_clk[d] / (int'(presc) + 1);
        bnd     = (m_clk[d] == (m_pq[d] + 1) * (int'(presc) + 1) - 1);
        for (int c = 0; c < 2; c++) e_pwm[d][c] = (cnt_now < m_cur[d][c]);
        e_ps[d] = bnd;
        if (bnd) begin
          m_clk[d] = 0;
          m_pq[d]  = int'(period);
          for (int c = 0; c < 2; c++) begin
            int s;
            int t;
            s = step_of(d);
            t = int'(duty_tgt[c*12 +: 12]);
            if (!m_drn[d][c]) begin
              if (dir_in[c] == m_dir[d][c]) m_cur[d][c] = toward(m_cur[d][c], t, s);
              else begin m_drn[d][c] = 1'b1; m_cur[d][c] = toward(m_cur[d][c], 0, s); end
            end else if (dir_in[c] == m_dir[d][c]) begin
              m_drn[d][c] = 1'b0; m_cur[d][c] = toward(m_cur[d][c], t, s);
            end else if (m_cur[d][c] == 0) begin
              m_dir[d][c] = ~m_dir[d][c]; m_drn[d][c] = 1'b0;
            end else begin
              m_cur[d][c] = toward(m_cur[d][c], 0, s);
            end
            m_tgt[d][c] = t;
          end
        end else begin
          m_clk[d] = m_clk[d] + 1;
        end
        for (int c = 0; c < 2; c++) e_busy[d][c] = (m_cur[d][c] != m_tgt[d][c]) || m_drn[d][c];
      end
    end
  endtask

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h t=%0t", tag, d, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check("pwm_out",      d, 32'(pwm_o[d]),  32'(e_pwm[d]));
      check("dir_out",      d, 32'(dir_o[d]),  32'(m_dir[d]));
      check("ramp_busy",    d, 32'(busy_o[d]), 32'(e_busy[d]));
      check("period_start", d, 32'(ps_o[d]),   32'(e_ps[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_pwm",  d, 32'(pwm_o[d]),  32'd0);
      check("rst_dir",  d, 32'(dir_o[d]),  32'd0);
      check("rst_busy", d, 32'(busy_o[d]), 32'd0);
      check("rst_ps",   d, 32'(ps_o[d]),   32'd0);
      model_clear(d);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ps(input int d, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      seen = ps_o[d];
    end
    check(tag, d, 32'(seen), 32'd1);
  endtask

  initial begin
    int hi;
    int pss;
    rst = 1'b1; en = 1'b0; presc = 8'd0; period = 12'd9;
    duty_tgt = 24'd0; dir_in = 2'b00;
    for (int d = 0; d < 2; d++) model_clear(d);
    run(3);
    rst = 1'b0;
    run(2);

    // Fixed duty, no prescale: 3 of every 10 clk high, one period_start per 10 clk.
    duty_tgt = {12'd7, 12'd3};
    en = 1'b1;
    run(40);
    hi = 0; pss = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      hi  += int'(pwm_o[0][0]);
      pss += int'(ps_o[0]);
    end
    check("fixed_high_time", 0, 32'(hi), 32'd3);
    check("fixed_ps_count",  0, 32'(pss), 32'd1);

    // Prescale 2 with ramp to 6: per-period high time 4, 8, 12 clk.
    en = 1'b0;
    step();
    presc = 8'd1; period = 12'd9; duty_tgt = {12'd6, 12'd6};
    step();
    en = 1'b1;
    wait_ps(1, "ramp_first_ps");
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        hi += int'(pwm_o[1][0]);
      end
      check("ramp_high_time", 1, 32'(hi), 32'(4 * (p + 1)));
    end
    check("ramp_busy_clear", 1, 32'(busy_o[1][0]), 32'd0);

    // Reversal on channel 0: drain, toggle, ramp back up.
    dir_in = 2'b01;
    run(200);
    check("rev_dir_step2", 1, 32'(dir_o[1][0]), 32'd1);
    check("rev_dir_step0", 0, 32'(dir_o[0][0]), 32'd1);

    // Reset mid-period while channel 1 drains.
    dir_in = 2'b11;
    wait_ps(1, "drain_ps");
    run(5);
    check("drain_busy", 1, 32'(busy_o[1][1]), 32'd1);
    pulse_reset();
    check("post_rst_dir1", 1, 32'(dir_o[1][1]), 32'd0);
    run(120);

    // Randomized segments with mid-period input changes, enable drops and resets.
    for (int seg = 0; seg < 30; seg++) begin
      en = 1'b0;
      presc    = 8'($urandom_range(0, 3));
      period   = 12'($urandom_range(2, 12));
      duty_tgt = {12'($urandom_range(0, 15)), 12'($urandom_range(0, 15))};
      dir_in   = 2'($urandom_range(0, 3));
      run(2);
      en = 1'b1;
      for (int k = 0; k < 80; k++) begin
        step();
        if ($urandom_range(0, 15) == 0)
          duty_tgt = {12'($urandom_range(0, 15)), 12'($urandom_range(0, 15))};
        if ($urandom_range(0, 31) == 0) dir_in[$urandom_range(0, 1)] ^= 1'b1;
        if ($urandom_range(0, 31) == 0) period = 12'($urandom_range(2, 12));
        if ($urandom_range(0, 63) == 0) begin
          en = 1'b0;
          run(int'($urandom_range(1, 3)));
          en = 1'b1;
        end
        if (k == 40 && seg % 7 == 3) pulse_reset();
      end
    end

    // Full-scale ramp up to 0xFFF and back down to 0 must never wrap.
    en = 1'b0;
    presc = 8'd0; period = 12'd3; dir_in = 2'b00;
    duty_tgt = {12'h800, 12'hFFF};
    run(2);
    en = 1'b1;
    run(8300);
    check("fullscale_busy", 1, 32'(busy_o[1][0]), 32'd0);
    check("fullscale_pwm",  1, 32'(pwm_o[1][0]),  32'd1);
    duty_tgt = 24'd0;
    run(8300);
    check("zero_busy", 1, 32'(busy_o[1]), 32'd0);
    check("zero_pwm",  1, 32'(pwm_o[1]),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
